spi_cmd_serializer: RTL and testbench

- SPI-slave-side transmit serializer for the control group.
- Accepts a command word {opcode, addr} from the local core via a valid/ready handshake.
- Shifts the word MSB-first onto miso when an external SPI master selects it with n_cs and clocks it with spi_clk (SPI mode 0).
- Flags protocol violations on err.

---
 rtl/spi_cmd_serializer_pkg.sv | 19 +
 rtl/spi_cmd_serializer_if.sv | 31 +++
 rtl/spi_cmd_serializer_edge_sync.sv | 39 +++
 rtl/spi_cmd_serializer.sv | 149 ++++++++++++++
 tb/tb_spi_cmd_serializer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_serializer_pkg.sv
// spi_cmd_serializer_pkg
// Shared definitions for the SPI command serializer:
//   OPCODEW_DEF / ADDRW_DEF : default field widths of the command word
//   W                       : default shift word width {opcode, addr}
//   state_t                 : transmit FSM state encoding (2 bits)
package spi_cmd_serializer_pkg;

    localparam int OPCODEW_DEF = 2;
    localparam int ADDRW_DEF   = 8;
    localparam int W           = OPCODEW_DEF + ADDRW_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/spi_cmd_serializer_if.sv
// spi_cmd_serializer_if
// Bundles the local-core load handshake and the SPI slave pins.
//   valid_in, opcode, addr, ready_out : command word handshake
//   n_cs, spi_clk, miso               : SPI bus (mode 0, slave side)
//   err                               : sticky protocol-error flag
// Modports: slave = serializer side, master = core/SPI-master side.
interface spi_cmd_serializer_if
    import spi_cmd_serializer_pkg::*;
#(
    parameter int OPCODEW = OPCODEW_DEF,
    parameter int ADDRW   = ADDRW_DEF
);
    logic               valid_in;
    logic [OPCODEW-1:0] opcode;
    logic [ADDRW-1:0]   addr;
    logic               ready_out;
    logic               n_cs;
    logic               spi_clk;
    logic               miso;
    logic               err;

    modport slave (
        input  valid_in, opcode, addr, n_cs, spi_clk,
        output ready_out, miso, err
    );

    modport master (
        output valid_in, opcode, addr, n_cs, spi_clk,
        input  ready_out, miso, err
    );
endinterface

// File: rtl/spi_cmd_serializer_edge_sync.sv
// spi_edge_sync
// Brings an asynchronous pin into the clk domain through two synchroniser
// flops, then a third flop that holds the previous synced value so that
// single-cycle rise/fall pulses can be produced.
//   clk, rst_n : system clock, async active-low reset
//   async_in   : raw asynchronous input pin
//   rise, fall : one-cycle pulses on a synced 0->1 / 1->0 transition
// RESET_VAL is the pin's idle level, so releasing reset with the pin idle
// does not produce a spurious edge.
module spi_edge_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RESET_VAL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[1] is the synchronised level, sync_q[2] its previous value.
    assign rise =  sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_cmd_serializer.sv
// spi_cmd_serializer
// SPI-slave transmit serializer. A {opcode, addr} word is accepted from the
// local core with valid/ready, then shifted MSB-first on miso while the
// external master holds n_cs low and toggles spi_clk (mode 0: master
// samples on rising edge, slave changes data on falling edge).
//   clk, rst_n : system clock, async active-low reset
//   bus.slave  : valid_in/opcode/addr/ready_out handshake,
//                n_cs/spi_clk in, miso out, sticky err out
// Underrun (selected with nothing loaded) and abort (deselected before the
// whole word was clocked out) set err; the next accepted load clears it.
module spi_cmd_serializer
    import spi_cmd_serializer_pkg::*;
#(
    parameter int OPCODEW = OPCODEW_DEF,
    parameter int ADDRW   = ADDRW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    spi_cmd_serializer_if.slave    bus
);

    localparam int WORDW = OPCODEW + ADDRW;
    localparam int CNTW  = $clog2(WORDW + 1);

    logic cs_rise;
    logic cs_fall;
    logic sck_rise;
    logic sck_fall;

    // n_cs idles high, spi_clk idles low in mode 0.
    spi_edge_sync #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.n_cs),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    spi_edge_sync #(.RESET_VAL(1'b0)) u_sck_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.spi_clk),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    state_t           state_q, state_d;
    logic [WORDW-1:0] shift_q, shift_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             miso_q, miso_d;
    logic             err_q, err_d;
    logic             err_set;
    logic             err_clr;
    logic             last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            err_q   <= err_d;
        end
    end

    // The rising edge that lets the master sample the final bit.
    assign last_bit = sck_rise && (cnt_q == CNTW'(WORDW - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        miso_d  = 1'b0;
        err_set = 1'b0;
        err_clr = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    err_set = 1'b1;
                end
                if (bus.valid_in) begin
                    shift_d = {bus.opcode, bus.addr};
                    err_clr = 1'b1;
                    state_d = LOADED;
                end
            end

            LOADED: begin
                if (cs_fall) begin
                    miso_d  = shift_q[WORDW-1];
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                miso_d = miso_q;
                // A deselect coinciding with the final sample edge still
                // counts as a complete transfer, so completion is tested first.
                if (last_bit) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    miso_d  = 1'b0;
                    state_d = DONE;
                end else if (cs_rise) begin
                    err_set = 1'b1;
                    shift_d = '0;
                    miso_d  = 1'b0;
                    state_d = IDLE;
                end else if (sck_rise) begin
                    cnt_d = cnt_q + CNTW'(1);
                end else if (sck_fall) begin
                    shift_d = {shift_q[WORDW-2:0], 1'b0};
                    miso_d  = shift_q[WORDW-2];
                end
            end

            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Setting wins over clearing when both happen in one cycle.
        if (err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.err       = err_q;
    assign bus.ready_out = (state_q == IDLE);

endmodule

// File: tb/tb_spi_cmd_serializer.sv
// tb_spi_cmd_serializer
// Directed bench for the SPI command serializer: a table of transfer
// vectors plus hand-written sequences for reset, underrun, back-pressure
// and reset in the middle of a transfer.
module tb_spi_cmd_serializer;
    import spi_cmd_serializer_pkg::*;

    localparam int SPI_HALF = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    spi_cmd_serializer_if bus ();

    spi_cmd_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 100 MHz system clock; SPI runs at clk/16.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] ad;
        int         pulses;
        logic       expErr;
        logic [9:0] expWord;
    } vec_t;

    vec_t vecs [4];

    // Compares one observed value against its required value and logs misses.
    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Presents one word on the handshake for a single clk edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] ad);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.opcode   = op;
        bus.addr     = ad;
        @(negedge clk);
        bus.valid_in = 1'b0;
    endtask

    // Selects the slave, clocks n mode-0 periods sampling miso on each rising
    // edge, then deselects. rx holds the first W samples, extraOr any 1 seen
    // after the W-th sample.
    task automatic spiTransfer(input int n, output logic [31:0] rx,
                               output logic extraOr);
        rx      = '0;
        extraOr = 1'b0;
        @(negedge clk);
        bus.n_cs = 1'b0;
        repeat (SPI_HALF) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i < W) begin
                rx = {rx[30:0], bus.miso};
            end else begin
                extraOr = extraOr | bus.miso;
            end
            bus.spi_clk = 1'b1;
            repeat (SPI_HALF) @(negedge clk);
            bus.spi_clk = 1'b0;
            repeat (SPI_HALF) @(negedge clk);
        end
        bus.n_cs = 1'b1;
    endtask

    // Bounded wait for ready_out, counted as a comparison.
    task automatic waitReady(input string name, input int maxCycles);
        int k;
        k = 0;
        while (bus.ready_out !== 1'b1 && k < maxCycles) begin
            @(negedge clk);
            k++;
        end
        checkOutput(name, {31'd0, bus.ready_out}, 32'd1);
    endtask

    initial begin
        logic [31:0] rx;
        logic [31:0] expRx;
        logic        extraOr;
        int          nBits;

        checks       = 0;
        errors       = 0;
        bus.valid_in = 1'b0;
        bus.opcode   = '0;
        bus.addr     = '0;
        bus.n_cs     = 1'b1;
        bus.spi_clk  = 1'b0;
        rst_n        = 1'b0;

        vecs[0] = '{name: "nominal", op: 2'b10, ad: 8'hA5, pulses: 10,
                    expErr: 1'b0, expWord: 10'b10_1010_0101};
        vecs[1] = '{name: "abort",   op: 2'b11, ad: 8'hFF, pulses: 4,
                    expErr: 1'b1, expWord: 10'h3FF};
        vecs[2] = '{name: "extra",   op: 2'b01, ad: 8'h55, pulses: 13,
                    expErr: 1'b0, expWord: 10'h155};
        vecs[3] = '{name: "edges",   op: 2'b00, ad: 8'h81, pulses: 10,
                    expErr: 1'b0, expWord: 10'h081};

        $display("[TB] reset values");
        repeat (3) @(negedge clk);
        checkOutput("rst_miso",  {31'd0, bus.miso},      32'd0);
        checkOutput("rst_ready", {31'd0, bus.ready_out}, 32'd1);
        checkOutput("rst_err",   {31'd0, bus.err},       32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("idle_miso",  {31'd0, bus.miso},      32'd0);
        checkOutput("idle_ready", {31'd0, bus.ready_out}, 32'd1);
        checkOutput("idle_err",   {31'd0, bus.err},       32'd0);

        $display("[TB] table vectors");
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].op, vecs[v].ad);
            checkOutput({vecs[v].name, "_ready_low"}, {31'd0, bus.ready_out}, 32'd0);
            spiTransfer(vecs[v].pulses, rx, extraOr);
            nBits = (vecs[v].pulses < W) ? vecs[v].pulses : W;
            expRx = '0;
            for (int b = 0; b < nBits; b++) begin
                expRx = {expRx[30:0], vecs[v].expWord[W-1-b]};
            end
            checkOutput({vecs[v].name, "_bits"},  rx, expRx);
            checkOutput({vecs[v].name, "_extra"}, {31'd0, extraOr}, 32'd0);
            waitReady({vecs[v].name, "_ready"}, 4);
            checkOutput({vecs[v].name, "_err"},  {31'd0, bus.err},  {31'd0, vecs[v].expErr});
            checkOutput({vecs[v].name, "_miso"}, {31'd0, bus.miso}, 32'd0);
            repeat (4) @(negedge clk);
        end

        $display("[TB] underrun");
        bus.n_cs = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("underrun_err",   {31'd0, bus.err},       32'd1);
        checkOutput("underrun_miso",  {31'd0, bus.miso},      32'd0);
        checkOutput("underrun_ready", {31'd0, bus.ready_out}, 32'd1);
        bus.n_cs = 1'b1;
        repeat (6) @(negedge clk);
        applyStimulus(2'b11, 8'h0F);
        checkOutput("underrun_clear", {31'd0, bus.err}, 32'd0);
        spiTransfer(10, rx, extraOr);
        checkOutput("after_underrun_bits", rx, 32'h30F);
        waitReady("after_underrun_ready", 4);
        repeat (4) @(negedge clk);

        $display("[TB] back-pressure");
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.opcode   = 2'b01;
        bus.addr     = 8'h5A;
        @(negedge clk);
        bus.addr = 8'h3C;
        repeat (10) @(negedge clk);
        checkOutput("bp_ready_low", {31'd0, bus.ready_out}, 32'd0);
        bus.valid_in = 1'b0;
        spiTransfer(10, rx, extraOr);
        checkOutput("bp_bits", rx, 32'h15A);
        waitReady("bp_ready", 4);
        checkOutput("bp_err", {31'd0, bus.err}, 32'd0);
        repeat (4) @(negedge clk);

        $display("[TB] reset mid-transfer");
        applyStimulus(2'b10, 8'hFF);
        @(negedge clk);
        bus.n_cs = 1'b0;
        repeat (SPI_HALF) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.spi_clk = 1'b1;
            repeat (SPI_HALF) @(negedge clk);
            bus.spi_clk = 1'b0;
            repeat (SPI_HALF) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_miso",  {31'd0, bus.miso},      32'd0);
        checkOutput("midrst_ready", {31'd0, bus.ready_out}, 32'd1);
        checkOutput("midrst_err",   {31'd0, bus.err},       32'd0);
        bus.n_cs = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("postrst_err",   {31'd0, bus.err},       32'd0);
        checkOutput("postrst_ready", {31'd0, bus.ready_out}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guards against a stalled run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
